// File: rtl/serial_rx_pkg.sv
`default_nettype none
//==============================================================================
// Module      : serial_rx_pkg
// Description : Shared types and constants for the serial receive controller.
//               The PARITY state exists only when SERIAL_RX_PARITY_CHECK_EN
//               is defined.
// Revision    : 1.0 - initial release
//==============================================================================
package serial_rx_pkg;

   // Serial word width shared by controller and datapath
   localparam int DATA_W             = 8;
   // Default number of consecutive low samples that qualify a start bit
   localparam int START_SAMPLES_DFLT = 2;
   // Start-sample counter width; wide enough for the legal range 1..4
   localparam int START_CNT_W        = 3;

   // Controller states; encodings are fixed so the two build variants agree
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INIT   = 3'd1,
      ST_SHIFT  = 3'd2,
`ifdef SERIAL_RX_PARITY_CHECK_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4,
      ST_VALID  = 3'd5
   } rx_state_t;

endpackage : serial_rx_pkg
`default_nettype wire

// File: rtl/serial_rx_controller_start_filter.sv
`default_nettype none
//==============================================================================
// Module      : start_filter
// Description : Counts consecutive low samples of the serial line while
//               enabled and emits a one-cycle start_det pulse on the sample
//               that makes the run START_SAMPLES long. Any high sample, or
//               dropping the enable, restarts the count.
// Revision    : 1.0 - initial release
//==============================================================================
module start_filter #(
   parameter int START_SAMPLES = serial_rx_pkg::START_SAMPLES_DFLT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_ser,
   input  logic i_enable,
   output logic o_start_det
);
   import serial_rx_pkg::*;

   logic [START_CNT_W-1:0] r_low_cnt;
   logic                   w_low;
   logic                   w_det;

   // A qualifying sample is a low line while the controller is listening
   assign w_low = i_enable && !i_ser;
   // The run completes on the sample after START_SAMPLES-1 lows were counted
   assign w_det = w_low && (r_low_cnt == START_CNT_W'(START_SAMPLES - 1));

   assign o_start_det = w_det;

   // Consecutive-low counter, restarted by a high sample or by a detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_low_cnt <= '0;
      end else if (!w_low || w_det) begin
         r_low_cnt <= '0;
      end else begin
         r_low_cnt <= r_low_cnt + START_CNT_W'(1);
      end
   end

endmodule : start_filter
`default_nettype wire

// File: rtl/serial_rx_controller.sv
`default_nettype none
//==============================================================================
// Module      : serial_rx_controller
// Description : Moore control FSM for a serial receiver. Qualifies a start
//               bit, initialises the external shift register and bit
//               counter, shifts DATA_W bits, checks the stop bit and holds
//               the word until the consumer acknowledges it. Reports framing
//               errors, parity errors and sticky receive overrun.
//               Optional feature macro: SERIAL_RX_PARITY_CHECK_EN adds an
//               even-parity bit after the data bits.
// Revision    : 1.0 - initial release
//==============================================================================
module serial_rx_controller #(
   parameter int START_SAMPLES = serial_rx_pkg::START_SAMPLES_DFLT,
   parameter int DATA_W        = serial_rx_pkg::DATA_W
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              SerI,
   input  logic              CO,
   input  logic [DATA_W-1:0] Data,
   input  logic              Ack,
   output logic              En_Reg,
   output logic              Init_Reg,
   output logic              Init_Cnt,
   output logic              Inc_Cnt,
   output logic              Valid,
   output logic              Busy,
   output logic              FrameErr,
   output logic              ParErr,
   output logic              Overrun
);
   import serial_rx_pkg::*;

   rx_state_t r_state;
   rx_state_t w_next;
   logic      w_start_en;
   logic      w_start_det;
   logic      r_frame_err;
   logic      r_overrun;

   // The line is watched for a start bit when idle and, for overrun, when a
   // word is still waiting for the consumer
   assign w_start_en = (r_state == ST_IDLE) || (r_state == ST_VALID);

   start_filter #(
      .START_SAMPLES (START_SAMPLES)
   ) u_start_filter (
      .clk         (Clk),
      .rst_n       (Rst),
      .i_ser       (SerI),
      .i_enable    (w_start_en),
      .o_start_det (w_start_det)
   );

   // State register; reset abandons any frame in progress
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic and Moore output decode from the state register
   always_comb begin
      w_next   = r_state;
      En_Reg   = 1'b0;
      Init_Reg = 1'b0;
      Init_Cnt = 1'b0;
      Inc_Cnt  = 1'b0;
      Valid    = 1'b0;
      Busy     = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (w_start_det) begin
               w_next = ST_INIT;
            end
         end
         ST_INIT: begin
            Init_Reg = 1'b1;
            Init_Cnt = 1'b1;
            w_next   = ST_SHIFT;
         end
         ST_SHIFT: begin
            En_Reg  = 1'b1;
            Inc_Cnt = 1'b1;
            if (CO) begin
`ifdef SERIAL_RX_PARITY_CHECK_EN
               w_next = ST_PARITY;
`else
               w_next = ST_STOP;
`endif
            end
         end
`ifdef SERIAL_RX_PARITY_CHECK_EN
         ST_PARITY: begin
            w_next = ST_STOP;
         end
`endif
         ST_STOP: begin
            w_next = SerI ? ST_VALID : ST_IDLE;
         end
         ST_VALID: begin
            Valid = 1'b1;
            if (Ack) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Framing error: one-cycle pulse after a stop bit sampled low
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= (r_state == ST_STOP) && !SerI;
      end
   end

   // Overrun: a start bit seen while the previous word is unread; sticky
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_overrun <= 1'b0;
      end else if ((r_state == ST_VALID) && w_start_det) begin
         r_overrun <= 1'b1;
      end
   end

   assign FrameErr = r_frame_err;
   assign Overrun  = r_overrun;

`ifdef SERIAL_RX_PARITY_CHECK_EN
   logic r_par_err;

   // Parity error: one-cycle pulse when the parity bit breaks even parity
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_par_err <= 1'b0;
      end else begin
         r_par_err <= (r_state == ST_PARITY) && (SerI != (^Data));
      end
   end

   assign ParErr = r_par_err;
`else
   // Shift-register contents matter only to the parity check
   logic w_unused_data;
   assign w_unused_data = ^Data;
   assign ParErr        = 1'b0;
`endif

endmodule : serial_rx_controller
`default_nettype wire

// File: tb/tb_serial_rx_controller.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_serial_rx_controller
// Description : Self-checking bench for serial_rx_controller. Models the
//               external shift register and bit counter, sends random
//               frames, and checks reported words and error pulses through
//               a scoreboard queue.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_serial_rx_controller;
   import serial_rx_pkg::*;

   localparam int SS = 2;
   localparam int DW = 8;

   logic          Clk = 1'b0;
   logic          Rst = 1'b0;
   logic          SerI = 1'b1;
   logic          Ack = 1'b0;
   logic          CO;
   logic [DW-1:0] Data;
   logic          En_Reg, Init_Reg, Init_Cnt, Inc_Cnt, Valid, Busy;
   logic          FrameErr, ParErr, Overrun;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 Clk = ~Clk;

   serial_rx_controller #(
      .START_SAMPLES (SS),
      .DATA_W        (DW)
   ) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .SerI     (SerI),
      .CO       (CO),
      .Data     (Data),
      .Ack      (Ack),
      .En_Reg   (En_Reg),
      .Init_Reg (Init_Reg),
      .Init_Cnt (Init_Cnt),
      .Inc_Cnt  (Inc_Cnt),
      .Valid    (Valid),
      .Busy     (Busy),
      .FrameErr (FrameErr),
      .ParErr   (ParErr),
      .Overrun  (Overrun)
   );

   // Datapath model: LSB-first shift register and bit counter
   logic [DW-1:0] m_sr;
   logic [4:0]    m_cnt;
   always @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         m_sr  <= '0;
         m_cnt <= '0;
      end else begin
         if (Init_Reg)    m_sr <= '0;
         else if (En_Reg) m_sr <= {SerI, m_sr[DW-1:1]};
         if (Init_Cnt)     m_cnt <= '0;
         else if (Inc_Cnt) m_cnt <= m_cnt + 5'd1;
      end
   end
   assign Data = m_sr;
   assign CO   = (m_cnt == 5'(DW - 1));

   // Scoreboard of expected word / error events in arrival order
   typedef enum int {EV_WORD, EV_FERR, EV_PERR} ev_kind_t;
   typedef struct {
      ev_kind_t      kind;
      logic [DW-1:0] data;
   } ev_t;
   ev_t sb_q[$];

   task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic expect_ev(input ev_kind_t k, input logic [DW-1:0] d);
      ev_t e;
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_bad++;
         $display("FAIL sb_unexpected: got %s data=%h, required no event at %0t", k.name(), d, $time);
      end else begin
         e = sb_q.pop_front();
         if (e.kind != k || (k == EV_WORD && e.data !== d)) begin
            n_bad++;
            $display("FAIL sb_event: got %s data=%h, required %s data=%h at %0t",
                     k.name(), d, e.kind.name(), e.data, $time);
         end
      end
   endtask

   // Monitor: every output event must match the next expectation
   logic prev_valid = 1'b0;
   always @(negedge Clk) begin
      if (Rst) begin
         if (ParErr)               expect_ev(EV_PERR, '0);
         if (FrameErr)             expect_ev(EV_FERR, '0);
         if (Valid && !prev_valid) expect_ev(EV_WORD, Data);
      end
      prev_valid = Valid;
   end

   // Drive one line sample and advance to the next falling edge
   task automatic drive(input logic v);
      SerI = v;
      @(negedge Clk);
   endtask

   // Send one frame with spec timing; push expectations first
   task automatic send_frame(input logic [DW-1:0] w, input bit bad_par, input bit stop_ok,
                             input int ack_dly, input bit ovr);
      int idle_n = $urandom_range(1, 4);
      if (bad_par) sb_q.push_back('{kind: EV_PERR, data: '0});
      if (stop_ok) sb_q.push_back('{kind: EV_WORD, data: w});
      else         sb_q.push_back('{kind: EV_FERR, data: '0});
      for (int i = 0; i < idle_n; i++) begin
         Ack = 1'($urandom_range(0, 1));
         drive(1'b1);
      end
      Ack = 1'b0;
      for (int i = 0; i < SS; i++) begin
         check("pre_start_busy", 16'(Busy), 16'h0);
         drive(1'b0);
      end
      check("init_ctl", 16'({Init_Reg, Init_Cnt, Busy, En_Reg, Inc_Cnt}), 16'b11100);
      drive(1'b0);
      for (int i = 0; i < DW; i++) begin
         check("shift_ctl", 16'({En_Reg, Inc_Cnt, Init_Reg, Valid}), 16'b1100);
         Ack = 1'($urandom_range(0, 1));
         drive(w[i]);
      end
      Ack = 1'b0;
`ifdef SERIAL_RX_PARITY_CHECK_EN
      check("parity_ctl", 16'({En_Reg, Inc_Cnt, Valid, Busy}), 16'b0001);
      drive((^w) ^ bad_par);
`endif
      check("stop_ctl", 16'({En_Reg, Inc_Cnt, Valid, Busy}), 16'b0001);
      drive(stop_ok);
      if (stop_ok) begin
         for (int i = 0; i < ack_dly; i++) begin
            check("valid_hold", 16'({Valid, Busy, En_Reg}), 16'b110);
            drive((ovr && i < SS) ? 1'b0 : 1'b1);
         end
         check("valid_before_ack", 16'(Valid), 16'h1);
         Ack = 1'b1;
         drive(1'b1);
         Ack = 1'b0;
         check("post_ack_idle", 16'({Valid, Busy}), 16'h0);
      end else begin
         check("ferr_idle", 16'({Valid, Busy, FrameErr}), 16'b001);
      end
   endtask

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst = 1'b0;
      repeat (3) @(negedge Clk);
      check("reset_outputs",
            16'({En_Reg, Init_Reg, Init_Cnt, Inc_Cnt, Valid, Busy, FrameErr, ParErr, Overrun}), 16'h0);
      #2 Rst = 1'b1;
      @(negedge Clk);
      check("idle_after_reset", 16'({Busy, Valid}), 16'h0);

      // Directed frame 1,1,1,0,1,1,0,1 with Ack delayed three cycles
      send_frame(8'hB7, 1'b0, 1'b1, 3, 1'b0);
`ifdef SERIAL_RX_PARITY_CHECK_EN
      send_frame(8'h5A, 1'b1, 1'b1, 1, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0);
`endif

      // Start glitch shorter than SS must not start a frame
      drive(1'b1);
      for (int i = 0; i < SS - 1; i++) drive(1'b0);
      drive(1'b1);
      check("glitch_no_init", 16'({Busy, Init_Reg}), 16'h0);
      drive(1'b1);
      check("glitch_idle", 16'(Busy), 16'h0);

      // Bad stop bit
      send_frame(8'($urandom), 1'b0, 1'b0, 0, 1'b0);

      // Random traffic
      for (int n = 0; n < 40; n++) begin
`ifdef SERIAL_RX_PARITY_CHECK_EN
         send_frame(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0),
                    $urandom_range(0, 3), 1'b0);
`else
         send_frame(8'($urandom), 1'b0, ($urandom_range(0, 5) != 0), $urandom_range(0, 3), 1'b0);
`endif
      end
      check("no_overrun_yet", 16'(Overrun), 16'h0);

      // Start while a word is pending: sticky overrun
      send_frame(8'($urandom), 1'b0, 1'b1, SS + 1, 1'b1);
      check("overrun_set", 16'(Overrun), 16'h1);
      send_frame(8'($urandom), 1'b0, 1'b1, 1, 1'b0);
      check("overrun_sticky", 16'(Overrun), 16'h1);

      // Reset pulse in the middle of SHIFT
      drive(1'b1);
      for (int i = 0; i < SS; i++) drive(1'b0);
      drive(1'b0);
      drive(1'b1);
      drive(1'b0);
      check("shift_before_reset", 16'(En_Reg), 16'h1);
      #1 Rst = 1'b0;
      #1 check("async_reset_outputs",
               16'({En_Reg, Init_Reg, Init_Cnt, Inc_Cnt, Valid, Busy, FrameErr, ParErr, Overrun}), 16'h0);
      #2 Rst = 1'b1;
      SerI = 1'b1;
      @(negedge Clk);
      check("idle_after_mid_reset", 16'({Busy, Overrun}), 16'h0);
      send_frame(8'($urandom), 1'b0, 1'b1, 1, 1'b0);
      send_frame(8'hC3, 1'b0, 1'b1, 0, 1'b0);
      check("overrun_cleared", 16'(Overrun), 16'h0);

      repeat (2) drive(1'b1);
      check("scoreboard_drained", 16'(sb_q.size()), 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_serial_rx_controller
`default_nettype wire
